// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - button-driven sequencing controller for the display counter
module counter_ctrl #(
  parameter int NUM_BITS  = 2,
  parameter int MAX_COUNT = 2**NUM_BITS - 1,
  parameter int PRESCALE  = 1,
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_start,
  input  logic                btn_stop,
  input  logic                btn_clear,
  input  logic [NUM_BITS-1:0] cnt_val,
  output logic                cnt_start,
  output logic                cnt_stop,
  output logic                cnt_rst,
  output logic [1:0]          state,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [2:0] CMD_CLR  = 3'b001;
  localparam logic [2:0] CMD_HOLD = 3'b010;
  localparam logic [2:0] CMD_INC  = 3'b100;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [NUM_BITS-1:0] MAX_VAL  = NUM_BITS'(MAX_COUNT);

  // bit 0 start, bit 1 stop, bit 2 clear
  logic [2:0] btn_raw;
  logic [2:0] sync_1;
  logic [2:0] sync_2;
  logic [2:0] sync_3;
  logic [2:0] pulse;
  logic       start_p;
  logic       stop_p;
  logic       clear_p;

  state_t     state_q;
  logic [PW-1:0] presc_q;
  logic       tick;
  logic       at_max;
  logic [2:0] cmd;

  assign btn_raw = {btn_clear, btn_stop, btn_start};
  assign pulse   = sync_2 & ~sync_3;
  assign start_p = pulse[0];
  assign stop_p  = pulse[1];
  assign clear_p = pulse[2];

  // Two-flop synchroniser per button plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      sync_3 <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign tick   = (state_q == ST_RUN) && (presc_q == PRE_LAST);
  assign at_max = (cnt_val == MAX_VAL);

  // Sequencing FSM and prescaler; the prescaler restarts only when a fresh run
  // begins from IDLE so that a PAUSE/resume keeps the partial interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
    end else if (clear_p) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p) begin
            state_q <= ST_RUN;
            presc_q <= '0;
          end
        end
        ST_RUN: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (stop_p) begin
            state_q <= ST_PAUSE;
          end else if (tick && at_max && AUTO_STOP) begin
            state_q <= ST_DONE;
          end
        end
        ST_PAUSE: begin
          if (start_p) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
      endcase
    end
  end

  // Counter command decode; only the three one-hot codes can ever be produced
  always_comb begin
    cmd = CMD_HOLD;
    case (state_q)
      ST_IDLE: cmd = CMD_CLR;
      ST_RUN: begin
        if (tick) begin
          if (!at_max) begin
            cmd = CMD_INC;
          end else if (AUTO_STOP) begin
            cmd = CMD_HOLD;
          end else begin
            cmd = CMD_CLR;
          end
        end
      end
      default: cmd = CMD_HOLD;
    endcase
  end

  assign {cnt_start, cnt_stop, cnt_rst} = cmd;
  assign state = state_q;
  assign done  = (state_q == ST_DONE);

  // Simulation-only sanity checks on parameters and the command encoding
  always_ff @(posedge clk) begin
    assert (MAX_COUNT <= 2**NUM_BITS - 1);
    assert (PRESCALE >= 1);
    assert ($onehot(cmd));
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl
module tb_counter_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;
  localparam logic [2:0] C_CLR   = 3'b001;
  localparam logic [2:0] C_HOLD  = 3'b010;
  localparam logic [2:0] C_INC   = 3'b100;

  logic clk;
  logic rst_n;

  // {clear, stop, start} per instance
  logic [2:0] btn_a, btn_b, btn_c;
  logic [2:0] cmd_a, cmd_b, cmd_c;
  logic [1:0] st_a, st_b, st_c;
  logic       done_a, done_b, done_c;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b, cnt_c;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [9:0] val;
  } exp_t;
  exp_t sb[$];

  counter_ctrl #(.NUM_BITS(4), .MAX_COUNT(15), .PRESCALE(3), .AUTO_STOP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_a[0]), .btn_stop(btn_a[1]), .btn_clear(btn_a[2]),
    .cnt_val(cnt_a),
    .cnt_start(cmd_a[2]), .cnt_stop(cmd_a[1]), .cnt_rst(cmd_a[0]),
    .state(st_a), .done(done_a)
  );

  counter_ctrl #(.NUM_BITS(2), .MAX_COUNT(3), .PRESCALE(1), .AUTO_STOP(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_b[0]), .btn_stop(btn_b[1]), .btn_clear(btn_b[2]),
    .cnt_val(cnt_b),
    .cnt_start(cmd_b[2]), .cnt_stop(cmd_b[1]), .cnt_rst(cmd_b[0]),
    .state(st_b), .done(done_b)
  );

  counter_ctrl #(.NUM_BITS(2), .MAX_COUNT(3), .PRESCALE(1), .AUTO_STOP(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_c[0]), .btn_stop(btn_c[1]), .btn_clear(btn_c[2]),
    .cnt_val(cnt_c),
    .cnt_start(cmd_c[2]), .cnt_stop(cmd_c[1]), .cnt_rst(cmd_c[0]),
    .state(st_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Display counters driven by the controllers' commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
      cnt_c <= '0;
    end else begin
      if (cmd_a == C_CLR) cnt_a <= '0; else if (cmd_a == C_INC) cnt_a <= cnt_a + 4'd1;
      if (cmd_b == C_CLR) cnt_b <= '0; else if (cmd_b == C_INC) cnt_b <= cnt_b + 2'd1;
      if (cmd_c == C_CLR) cnt_c <= '0; else if (cmd_c == C_INC) cnt_c <= cnt_c + 2'd1;
    end
  end

  function automatic logic [9:0] observe(input int which);
    case (which)
      0:       return {st_a, cmd_a, done_a, cnt_a};
      1:       return {st_b, cmd_b, done_b, 2'b00, cnt_b};
      default: return {st_c, cmd_c, done_c, 2'b00, cnt_c};
    endcase
  endfunction

  task automatic push(input string tag, input logic [1:0] st, input logic [2:0] cm, input logic [3:0] cv);
    exp_t e;
    e.tag = tag;
    e.val = {st, cm, (st == S_DONE), cv};
    sb.push_back(e);
  endtask

  task automatic cmp(input int which);
    exp_t e;
    logic [9:0] o;
    @(negedge clk);
    e = sb.pop_front();
    o = observe(which);
    n_cmp++;
    assert (o === e.val) else begin
      n_err++;
      $error("FAIL %s: observed st/cmd/done/cnt=%b_%b_%b_%b expected %b_%b_%b_%b", e.tag,
             o[9:8], o[7:5], o[4], o[3:0], e.val[9:8], e.val[7:5], e.val[4], e.val[3:0]);
    end
  endtask

  task automatic step(input int which, input string tag, input logic [1:0] st,
                      input logic [2:0] cm, input logic [3:0] cv);
    push(tag, st, cm, cv);
    cmp(which);
  endtask

  task automatic chk_legal(input string tag, input logic [2:0] cm);
    n_cmp++;
    assert ((cm == C_CLR) || (cm == C_INC) || (cm == C_HOLD)) else begin
      n_err++;
      $error("FAIL %s: observed cmd=%b expected one of 001/010/100", tag, cm);
    end
  endtask

  task automatic chk_reset(input string tag, input logic [1:0] st, input logic [2:0] cm, input logic d);
    n_cmp++;
    assert ({st, cm, d} === {S_IDLE, C_CLR, 1'b0}) else begin
      n_err++;
      $error("FAIL %s: observed st/cmd/done=%b_%b_%b expected 00_001_0", tag, st, cm, d);
    end
  endtask

  function automatic logic [2:0] rand_btn();
    logic [2:0] b;
    for (int k = 0; k < 3; k++) b[k] = ($urandom_range(0, 5) == 0);
    return b;
  endfunction

  initial begin
    rst_n = 1'b0;
    btn_a = '0;
    btn_b = '0;
    btn_c = '0;

    // Reset state and quiet idle after release
    step(0, "rst_a", S_IDLE, C_CLR, 4'd0);
    step(1, "rst_b", S_IDLE, C_CLR, 4'd0);
    step(2, "rst_c", S_IDLE, C_CLR, 4'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, "idle_a", S_IDLE, C_CLR, 4'd0);

    // Prescaled run, PRESCALE=3; start held to show a single pulse
    btn_a[0] = 1'b1;
    step(0, "start_lat1", S_IDLE, C_CLR, 4'd0);
    step(0, "start_lat2", S_IDLE, C_CLR, 4'd0);
    for (int i = 0; i < 8; i++)
      step(0, "run_presc", S_RUN, ((i % 3) == 2) ? C_INC : C_HOLD, 4'(i / 3));

    // Pause mid-interval, hold, then resume with the remaining prescale count
    btn_a[0] = 1'b0;
    btn_a[1] = 1'b1;
    step(0, "stop_lat1", S_RUN, C_INC, 4'd2);
    step(0, "stop_lat2", S_RUN, C_HOLD, 4'd3);
    step(0, "pause_in", S_PAUSE, C_HOLD, 4'd3);
    btn_a[1] = 1'b0;
    for (int i = 0; i < 20; i++) step(0, "pause_hold", S_PAUSE, C_HOLD, 4'd3);
    btn_a[0] = 1'b1;
    step(0, "resume_lat1", S_PAUSE, C_HOLD, 4'd3);
    step(0, "resume_lat2", S_PAUSE, C_HOLD, 4'd3);
    step(0, "resume_run", S_RUN, C_HOLD, 4'd3);
    step(0, "resume_tick", S_RUN, C_INC, 4'd3);
    step(0, "resume_inc", S_RUN, C_HOLD, 4'd4);
    btn_a[0] = 1'b0;

    // AUTO_STOP=1 terminal count, start/stop ignored in DONE, clear leaves
    btn_b[0] = 1'b1;
    step(1, "b_lat1", S_IDLE, C_CLR, 4'd0);
    step(1, "b_lat2", S_IDLE, C_CLR, 4'd0);
    step(1, "b_run0", S_RUN, C_INC, 4'd0);
    step(1, "b_run1", S_RUN, C_INC, 4'd1);
    btn_b[0] = 1'b0;
    step(1, "b_run2", S_RUN, C_INC, 4'd2);
    step(1, "b_term", S_RUN, C_HOLD, 4'd3);
    step(1, "b_done", S_DONE, C_HOLD, 4'd3);
    step(1, "b_done2", S_DONE, C_HOLD, 4'd3);
    btn_b[1:0] = 2'b11;
    for (int i = 0; i < 4; i++) step(1, "b_done_ign", S_DONE, C_HOLD, 4'd3);
    btn_b = 3'b100;
    step(1, "b_clr_lat1", S_DONE, C_HOLD, 4'd3);
    step(1, "b_clr_lat2", S_DONE, C_HOLD, 4'd3);
    step(1, "b_clr_idle", S_IDLE, C_CLR, 4'd3);
    step(1, "b_clr_cnt0", S_IDLE, C_CLR, 4'd0);
    btn_b = '0;

    // AUTO_STOP=0 wrap through a clear command while staying in RUN
    btn_c[0] = 1'b1;
    step(2, "c_lat1", S_IDLE, C_CLR, 4'd0);
    step(2, "c_lat2", S_IDLE, C_CLR, 4'd0);
    step(2, "c_run0", S_RUN, C_INC, 4'd0);
    step(2, "c_run1", S_RUN, C_INC, 4'd1);
    btn_c[0] = 1'b0;
    step(2, "c_run2", S_RUN, C_INC, 4'd2);
    step(2, "c_wrap", S_RUN, C_CLR, 4'd3);
    step(2, "c_after0", S_RUN, C_INC, 4'd0);
    step(2, "c_after1", S_RUN, C_INC, 4'd1);

    // Stop beats start; clear beats both
    btn_c = 3'b011;
    step(2, "c_ss_lat1", S_RUN, C_INC, 4'd2);
    step(2, "c_ss_lat2", S_RUN, C_CLR, 4'd3);
    step(2, "c_ss_pause", S_PAUSE, C_HOLD, 4'd0);
    btn_c = 3'b000;
    for (int i = 0; i < 3; i++) step(2, "c_pause", S_PAUSE, C_HOLD, 4'd0);
    btn_c = 3'b111;
    step(2, "c_all_lat1", S_PAUSE, C_HOLD, 4'd0);
    step(2, "c_all_lat2", S_PAUSE, C_HOLD, 4'd0);
    step(2, "c_all_idle", S_IDLE, C_CLR, 4'd0);
    btn_c = 3'b000;

    // Random buttons with random asynchronous resets: command stays one-hot
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      chk_legal("rnd_legal_a", cmd_a);
      chk_legal("rnd_legal_b", cmd_b);
      chk_legal("rnd_legal_c", cmd_c);
      btn_a = rand_btn();
      btn_b = rand_btn();
      btn_c = rand_btn();
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        chk_reset("rnd_rst_a", st_a, cmd_a, done_a);
        chk_reset("rnd_rst_b", st_b, cmd_b, done_b);
        chk_reset("rnd_rst_c", st_c, cmd_c, done_c);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Button already held when reset releases produces a pulse after two edges
    btn_a = 3'b001;
    btn_b = '0;
    btn_c = '0;
    rst_n = 1'b0;
    step(0, "held_rst", S_IDLE, C_CLR, 4'd0);
    rst_n = 1'b1;
    step(0, "held_lat1", S_IDLE, C_CLR, 4'd0);
    step(0, "held_lat2", S_IDLE, C_CLR, 4'd0);
    step(0, "held_run", S_RUN, C_HOLD, 4'd0);
    btn_a = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
